// File: rtl/soc_bus_pkg.sv
// Shared bus types and the default memory map for the CPU-side decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package soc_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ERR, RESP} state_t;

    typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_NONE} sel_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Region map, also consumed by the linker script and the bench
    localparam logic [31:0] S0_BASE_DEF   = 32'h0000_0000;
    localparam logic [31:0] S0_MASK_DEF   = 32'hFFFF_0000;
    localparam logic [31:0] S1_BASE_DEF   = 32'h1000_0000;
    localparam logic [31:0] S1_MASK_DEF   = 32'hFFFF_F000;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEF   = 16;

    function automatic int cnt_width(input int cycles);
        return (cycles <= 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mem_bus_addr_match.sv
// Base/mask region compare for one decoder window.
// Latency: combinational.
// Backpressure: none.
module mem_bus_addr_match (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] mask,
    output logic        hit
);

    assign hit = ((addr & mask) == base);

endmodule

// File: rtl/mem_bus_decoder.sv
// Routes CPU memory requests to SRAM or peripheral window, one at a time, with timeout.
// Latency: m_ready 3 cycles after accept for 0-wait slaves and unmapped accesses.
// Backpressure: CPU is held via m_ready; new requests are taken only in IDLE with m_ready low.
module mem_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter logic [31:0] S0_BASE        = S0_BASE_DEF,
    parameter logic [31:0] S0_MASK        = S0_MASK_DEF,
    parameter logic [31:0] S1_BASE        = S1_BASE_DEF,
    parameter logic [31:0] S1_MASK        = S1_MASK_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_instr,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic [31:0] m_rdata,
    output logic        m_ready,
    output logic        s0_valid,
    output logic [31:0] s0_addr,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    input  logic [31:0] s0_rdata,
    input  logic        s0_ready,
    output logic        s1_valid,
    output logic [31:0] s1_addr,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    input  logic [31:0] s1_rdata,
    input  logic        s1_ready,
    output logic        err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    sel_t             sel;
    req_t             req;
    logic [CNT_W-1:0] cnt;
    logic             hit_s0, hit_s1;
    logic             accept, slave_rdy, timeout_hit;
    logic [31:0]      slave_rdata;

    // Fetch flag plays no part in decode; both windows serve code and data.
    logic unused_instr;
    assign unused_instr = m_instr;

    mem_bus_addr_match u_match_s0 (.addr(m_addr), .base(S0_BASE), .mask(S0_MASK), .hit(hit_s0));
    mem_bus_addr_match u_match_s1 (.addr(m_addr), .base(S1_BASE), .mask(S1_MASK), .hit(hit_s1));

    always_comb begin
        slave_rdy   = 1'b0;
        slave_rdata = '0;
        case (sel)
            SEL_S0: begin
                slave_rdy   = s0_ready;
                slave_rdata = s0_rdata;
            end
            SEL_S1: begin
                slave_rdy   = s1_ready;
                slave_rdata = s1_rdata;
            end
            default: ;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // m_ready high means the CPU may still be showing the request just answered
                if (m_valid && !m_ready) begin
                    accept    = 1'b1;
                    state_nxt = (hit_s0 || hit_s1) ? WAIT : ERR;
                end
            end
            WAIT: begin
                if (slave_rdy)        state_nxt = RESP;
                else if (timeout_hit) state_nxt = ERR;
            end
            ERR:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_ready  <= 1'b0;
            m_rdata  <= '0;
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            req      <= '0;
            sel      <= SEL_NONE;
            cnt      <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            m_ready <= (state == RESP);
            cnt     <= (state == WAIT) ? cnt + 1'b1 : '0;

            if (accept) begin
                req      <= '{addr: m_addr, wdata: m_wdata, wstrb: m_wstrb};
                sel      <= hit_s0 ? SEL_S0 : (hit_s1 ? SEL_S1 : SEL_NONE);
                s0_valid <= hit_s0;
                s1_valid <= !hit_s0 && hit_s1;
            end else if (state == WAIT && state_nxt != WAIT) begin
                s0_valid <= 1'b0;
                s1_valid <= 1'b0;
            end

            if (state == WAIT && slave_rdy) m_rdata <= slave_rdata;
            else if (state == ERR)          m_rdata <= ERR_RDATA;

            // First error is kept unless software clears in the same cycle
            if (state == ERR && (!err || err_clr)) begin
                err      <= 1'b1;
                err_addr <= req.addr;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end
        end
    end

    assign s0_addr  = req.addr;
    assign s0_wdata = req.wdata;
    assign s0_wstrb = req.wstrb;
    assign s1_addr  = req.addr;
    assign s1_wdata = req.wdata;
    assign s1_wstrb = req.wstrb;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Randomized transaction bench for mem_bus_decoder against a region/latency model.
module tb_mem_bus_decoder;
    import soc_bus_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_instr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [31:0] s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        err, err_clr;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic        mdl_err;
    logic [31:0] mdl_err_addr;

    always #5 clk = ~clk;

    mem_bus_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_rdata(s0_rdata), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_rdata(s1_rdata), .s1_ready(s1_ready),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 = SRAM (first 64 KiB), 1 = peripheral 4 KiB window at 0x1000_0000, 2 = unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 1;
        return 2;
    endfunction

    task automatic idle_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_valid  = 1'b0;
            err_clr  = 1'b0;
            s0_ready = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s1_ready = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (m_ready || s0_valid || s1_valid) bad++;
        end
        @(negedge clk);
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (m_ready || s0_valid || s1_valid) bad++;
        chk(tag, bad, 0);
    endtask

    // delay: cycles of WAIT before the slave answers; negative = never answers
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int delay,
                           input logic [31:0] rdata, input bit clr, input bit drop_vld);
        int tgt, exp_vld, exp_lat, n0, n1, lat, hold_bad;
        bit to, is_err;
        logic [31:0] exp_rdata;
        tgt       = region(addr);
        to        = (tgt != 2) && (delay < 0 || delay >= TMO);
        is_err    = (tgt == 2) || to;
        exp_vld   = (tgt == 2) ? 0 : (to ? TMO : delay + 1);
        exp_lat   = (tgt == 2) ? 3 : (to ? TMO + 3 : delay + 3);
        exp_rdata = is_err ? ERR_RDATA_DEF : rdata;
        n0 = 0; n1 = 0; lat = 0; hold_bad = 0;

        @(negedge clk);
        m_valid = 1'b1;
        m_instr = 1'($urandom_range(0, 1));
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            err_clr  = clr && (c == 1);
            if (drop_vld) m_valid = 1'b0;
            s0_ready = 1'b0;
            s1_ready = 1'b0;
            s0_rdata = $urandom;
            s1_rdata = $urandom;
            if (s0_valid) begin
                n0++;
                if (s0_addr !== addr || s0_wdata !== wdata || s0_wstrb !== wstrb) hold_bad++;
            end
            if (s1_valid) begin
                n1++;
                if (s1_addr !== addr || s1_wdata !== wdata || s1_wstrb !== wstrb) hold_bad++;
            end
            if (tgt == 0 && s0_valid && n0 - 1 == delay) begin
                s0_ready = 1'b1;
                s0_rdata = rdata;
            end
            if (tgt == 1 && s1_valid && n1 - 1 == delay) begin
                s1_ready = 1'b1;
                s1_rdata = rdata;
            end
            if (tgt != 0 && $urandom_range(0, 2) == 0) s0_ready = 1'b1;
            if (tgt != 1 && $urandom_range(0, 2) == 0) s1_ready = 1'b1;
            if (m_ready) begin
                lat = c;
                break;
            end
        end
        m_valid  = 1'b0;
        err_clr  = 1'b0;

        if (clr) begin
            mdl_err      = is_err;
            mdl_err_addr = is_err ? addr : 32'h0;
        end else if (is_err && !mdl_err) begin
            mdl_err      = 1'b1;
            mdl_err_addr = addr;
        end

        chk("latency", lat, exp_lat);
        chk("m_rdata", m_rdata, exp_rdata);
        chk("s0_vld_cycles", n0, (tgt == 0) ? exp_vld : 0);
        chk("s1_vld_cycles", n1, (tgt == 1) ? exp_vld : 0);
        chk("slave_hold", hold_bad, 0);
        chk("err", err, mdl_err);
        chk("err_addr", err_addr, mdl_err_addr);
        idle_check("single_ready");
    endtask

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s0_ready = 1'b0; s1_ready = 1'b0; s0_rdata = '0; s1_rdata = '0; err_clr = 1'b0;
        mdl_err = 1'b0; mdl_err_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_s0_valid", s0_valid, 0);
        chk("rst_s1_valid", s1_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_s0_addr", s0_addr, 0);
        reset = 1'b0;

        run_txn(32'h0000_0010, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0, 1'b0);
        run_txn(32'h1000_0004, 32'hCAFE_F00D, 4'b0011, 2, 32'h0, 1'b0, 1'b0);
        run_txn(32'h2000_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
        run_txn(32'h3000_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
        run_txn(32'h0000_0020, 32'h0, 4'b0000, 1, 32'h0BAD_CAFE, 1'b1, 1'b0);
        run_txn(32'h1000_0100, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b0);
        run_txn(32'h4000_0040, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 1'b0);

        // Reset while the SRAM slave is being waited on
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0000_0200; m_wstrb = 4'b0000;
        @(negedge clk);
        chk("rst_wait_s0_valid", s0_valid, 1);
        m_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait_s0_drop", s0_valid, 0);
        chk("rst_wait_m_ready", m_ready, 0);
        chk("rst_wait_err", err, 0);
        mdl_err = 1'b0; mdl_err_addr = '0;
        idle_check("rst_wait_no_resp");
        run_txn(32'h0000_0300, 32'h0, 4'b0000, 0, 32'hA5A5_5A5A, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            logic [31:0] a;
            int d;
            case ($urandom_range(0, 3))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = 32'h1000_0000 | 32'($urandom_range(0, 32'hFFF));
                2:       a = 32'h1000_1000 + 32'($urandom_range(0, 32'hFFFF));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       d = -1;
                1:       d = TMO + $urandom_range(0, 3);
                2:       d = TMO - 1;
                default: d = $urandom_range(0, 5);
            endcase
            run_txn(a, $urandom, 4'($urandom), d, $urandom,
                    ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
